incr_step_ctrl: RTL and testbench

- Sequential control stage around the combinational 4-bit incrementer.
- Synchronises and debounces a push-button, then emits a one-cycle step strobe.
- Holds the accumulator register: its output `q` drives the incrementer input. On each accepted step it loads the incrementer's sum and carry back into the register.
- Also drives the board LEDs.

---
 rtl/incr_step_ctrl_pkg.sv | 19 +
 rtl/incr_step_ctrl_btn_sync_debounce.sv | 127 ++++++++++++
 rtl/incr_step_ctrl.sv | 66 ++++++
 tb/tb_incr_step_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/incr_step_ctrl_pkg.sv
// Shared types and defaults for the incrementer step controller.
// Defaults assume a 27 MHz board clock.
package incr_pkg;

    localparam int INCR_WIDTH = 4;
    localparam int CLK_HZ     = 27000000;

    // 10 ms debounce window, 0.5 s auto-repeat period
    localparam int DEBOUNCE_CYCLES_DFLT = CLK_HZ / 100;
    localparam int REPEAT_CYCLES_DFLT   = CLK_HZ / 2;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

endpackage

// File: rtl/incr_step_ctrl_btn_sync_debounce.sv
// Button front end: two-flop synchroniser, debounce FSM and one-cycle step strobe.
// Auto-repeat while held is built only when INCR_STEP_CTRL_AUTO_REPEAT_EN is defined.
module btn_sync_debounce
    import incr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic step_o
);

    // IDLE: released | PRESS_WAIT: debouncing press | HELD: pressed | RELEASE_WAIT: debouncing release
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic           REL_LVL  = BTN_ACTIVE_LOW;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
        $error("btn_sync_debounce: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    logic          sync1_q, sync2_q;
    logic          pressed;
    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fsm_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= REL_LVL;
            sync2_q <= REL_LVL;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed = sync2_q ^ REL_LVL;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fsm_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    cnt_d   = '0;
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    state_d  = HELD;
                    fsm_step = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    cnt_d   = '0;
                    state_d = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    cnt_d   = '0;
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

`ifdef INCR_STEP_CTRL_AUTO_REPEAT_EN
    localparam int              RCW      = $clog2(REPEAT_CYCLES);
    localparam logic [RCW-1:0]  REP_LAST = RCW'(REPEAT_CYCLES - 1);

    logic [RCW-1:0] rep_q, rep_d;
    logic           rep_fire;

    // Held cycles are counted only while HELD still sees the button down.
    always_comb begin
        rep_d    = '0;
        rep_fire = 1'b0;
        if (state_q == HELD && pressed) begin
            if (rep_q == REP_LAST) begin
                rep_fire = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end

    assign step_o = fsm_step | rep_fire;
`else
    assign step_o = fsm_step;
`endif

endmodule

// File: rtl/incr_step_ctrl.sv
// Step controller around the 4-bit incrementer: debounced button, accumulator, sticky overflow.
// Optional auto-repeat while held: define INCR_STEP_CTRL_AUTO_REPEAT_EN.
module incr_step_ctrl
    import incr_pkg::*;
#(
    parameter int WIDTH           = INCR_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_raw,
    input  logic             clr,
    input  logic [WIDTH-1:0] inc_sum,
    input  logic             inc_cout,
    output logic [WIDTH-1:0] q,
    output logic             step,
    output logic             ovf,
    output logic [WIDTH-1:0] led_n
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;

    btn_sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_btn (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw_i (btn_raw),
        .step_o    (step)
    );

    // clr wins over a coincident step; the strobe itself is untouched.
    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (clr) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (step) begin
            q_d = inc_sum;
            if (inc_cout) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q     = q_q;
    assign ovf   = ovf_q;
    assign led_n = ~q_q;

endmodule

// File: tb/tb_incr_step_ctrl.sv
// Self-checking bench for incr_step_ctrl with a short debounce window.
// Reference model tracks the accepted button level and run length of disagreeing samples.
module tb_incr_step_ctrl;

    localparam int W = 4;
    localparam int D = 4;
    localparam int R = 8;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         btn_raw  = 1'b1;
    logic         clr      = 1'b0;
    logic [W-1:0] inc_sum  = '0;
    logic         inc_cout = 1'b0;
    logic [W-1:0] q, led_n;
    logic         step, ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int step_cnt = 0;
    int last_step_cyc = -1;

    // Reference model state
    bit           hist[$];
    bit           m_level;
    int           m_run;
    int           m_hr;
    bit           m_prev_seen;
    logic [W-1:0] m_q;
    bit           m_ovf;

    always #5 clk = ~clk;

    incr_step_ctrl #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .BTN_ACTIVE_LOW  (1'b1),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .clr      (clr),
        .inc_sum  (inc_sum),
        .inc_cout (inc_cout),
        .q        (q),
        .step     (step),
        .ovf      (ovf),
        .led_n    (led_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
        m_level     = 1'b0;
        m_run       = 0;
        m_hr        = 0;
        m_prev_seen = 1'b0;
        m_q         = '0;
        m_ovf       = 1'b0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic cycle();
        bit seen     = 1'b0;
        bit exp_step = 1'b0;
        int run_now  = 0;
        int hr_now   = 0;
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            seen     = hist[0];
            run_now  = (seen != m_level) ? m_run + 1 : 0;
            exp_step = !m_level && (run_now == D + 1);
`ifdef INCR_STEP_CTRL_AUTO_REPEAT_EN
            hr_now = (m_level && seen && m_prev_seen) ? m_hr + 1 : 0;
            if (hr_now == R) begin
                exp_step = 1'b1;
                hr_now   = 0;
            end
`endif
        end
        check("step",  {31'd0, step}, {31'd0, exp_step});
        check("q",     {28'd0, q},     {28'd0, m_q});
        check("ovf",   {31'd0, ovf},   {31'd0, m_ovf});
        check("led_n", {28'd0, led_n}, {28'd0, ~m_q});
        if (step === 1'b1) begin
            step_cnt++;
            last_step_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            if (clr) begin
                m_q   = '0;
                m_ovf = 1'b0;
            end else if (exp_step) begin
                m_q = inc_sum;
                if (inc_cout) m_ovf = 1'b1;
            end
            if (run_now == D + 1) begin
                m_level = !m_level;
                m_run   = 0;
            end else begin
                m_run = run_now;
            end
            m_hr        = hr_now;
            m_prev_seen = seen;
            hist.push_back(~btn_raw);
            if (hist.size() > 2) void'(hist.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic press_release(input int hold);
        btn_raw = 1'b0;
        repeat (hold) cycle();
        btn_raw = 1'b1;
        repeat (20) cycle();
    endtask

    initial begin
        int s0, c0, c1, len;
        model_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);

        // Reset state
        repeat (3) cycle();
        check("rst_q",     {28'd0, q},     32'h0);
        check("rst_ovf",   {31'd0, ovf},   32'h0);
        check("rst_step",  {31'd0, step},  32'h0);
        check("rst_led_n", {28'd0, led_n}, 32'hF);

        rst_n = 1'b1;
        s0 = step_cnt;
        repeat (100) cycle();
        check("idle_no_step", step_cnt - s0, 0);

        // Clean press
        inc_sum = 4'h1; inc_cout = 1'b0;
        s0 = step_cnt; c0 = cyc;
        btn_raw = 1'b0;
        repeat (20) cycle();
        check("press_steps",   step_cnt - s0, 1);
        check("press_latency", last_step_cyc - c0, 6);
        check("press_q",       {28'd0, q},     32'h1);
        check("press_led_n",   {28'd0, led_n}, 32'hE);
        btn_raw = 1'b1;
        repeat (20) cycle();
        check("release_no_step", step_cnt - s0, 1);

        // Bounce
        inc_sum = 4'h2;
        s0 = step_cnt;
        for (int i = 0; i < 6; i++) begin
            btn_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) cycle();
        end
        c0 = cyc;
        btn_raw = 1'b0;
        repeat (20) cycle();
        check("bounce_steps",   step_cnt - s0, 1);
        check("bounce_latency", last_step_cyc - c0, 6);
        check("bounce_q",       {28'd0, q}, 32'h2);
        btn_raw = 1'b1;
        repeat (20) cycle();

        // Overflow is sticky until clr
        inc_sum = 4'h0; inc_cout = 1'b1;
        press_release(20);
        check("ovf_q",   {28'd0, q},   32'h0);
        check("ovf_set", {31'd0, ovf}, 32'h1);
        inc_sum = 4'h5; inc_cout = 1'b0;
        press_release(20);
        check("ovf_sticky",   {31'd0, ovf}, 32'h1);
        check("ovf_sticky_q", {28'd0, q},   32'h5);
        clr = 1'b1; cycle(); clr = 1'b0; cycle();
        check("clr_ovf", {31'd0, ovf}, 32'h0);
        check("clr_q",   {28'd0, q},   32'h0);

        // clr coincident with step
        inc_sum = 4'h3; inc_cout = 1'b1;
        press_release(20);
        check("pre_clr_ovf", {31'd0, ovf}, 32'h1);
        inc_sum = 4'h7;
        s0 = step_cnt; c0 = cyc;
        btn_raw = 1'b0;
        repeat (6) cycle();
        clr = 1'b1; cycle(); clr = 1'b0;
        repeat (13) cycle();
        check("clrstep_steps", step_cnt - s0, 1);
        check("clrstep_cyc",   last_step_cyc - c0, 6);
        check("clrstep_q",     {28'd0, q},   32'h0);
        check("clrstep_ovf",   {31'd0, ovf}, 32'h0);
        btn_raw = 1'b1; inc_cout = 1'b0;
        repeat (20) cycle();

        // Reset mid-PRESS_WAIT with button held
        inc_sum = 4'h9;
        btn_raw = 1'b0;
        repeat (5) cycle();
        rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        s0 = step_cnt; c1 = cyc;
        repeat (14) cycle();
        check("rst_mid_steps",   step_cnt - s0, 1);
        check("rst_mid_latency", last_step_cyc - c1, 6);
        check("rst_mid_q",       {28'd0, q}, 32'h9);
        btn_raw = 1'b1;
        repeat (20) cycle();

        // Long hold: auto-repeat or a single step
        inc_sum = 4'hA;
        s0 = step_cnt; c0 = cyc;
        btn_raw = 1'b0;
        repeat (31) cycle();
`ifdef INCR_STEP_CTRL_AUTO_REPEAT_EN
        check("hold_steps",    step_cnt - s0, 4);
        check("hold_last_cyc", last_step_cyc - c0, 30);
`else
        check("hold_steps",    step_cnt - s0, 1);
        check("hold_last_cyc", last_step_cyc - c0, 6);
`endif
        btn_raw = 1'b1;
        repeat (20) cycle();

        // Randomised button runs, data, clr and occasional reset
        for (int seg = 0; seg < 250; seg++) begin
            btn_raw = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                repeat (2) cycle();
                rst_n = 1'b1;
            end
            repeat (len) begin
                inc_sum  = W'($urandom);
                inc_cout = 1'($urandom);
                clr      = ($urandom_range(0, 15) == 0);
                cycle();
            end
        end
        clr = 1'b0;
        btn_raw = 1'b1;
        repeat (20) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
